uart_tx_seq: RTL and testbench

UART_TX_SEQ -- requirements
Module: uart_tx_seq

---
 rtl/uart_tx_seq.sv | 152 +++++++++++++++
 tb/tb_uart_tx_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_seq.sv
// Word FIFO feeding a byte-serialising sequencer for a UART transmitter.
// Each queued word carries 1..4 bytes, handed out with a start/busy handshake.
module uart_tx_seq #(
    parameter int DEPTH_LOG2 = 2,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic [1:0]  wr_len,
    output logic        full,
    output logic        ovf,
    input  logic        tx_busy,
    output logic [7:0]  sdata,
    output logic        tx_start,
    output logic        idle
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_HI,
        WAIT_LO
    } state_t;

    logic [33:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wp_q;
    logic [DEPTH_LOG2-1:0] rp_q;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic                  ovf_q;

    state_t      state_q;
    logic [31:0] shreg_q;
    logic [1:0]  rem_q;
    logic [2:0]  to_q;
    logic [7:0]  sdata_q;
    logic        start_q;

    logic       push;
    logic       pop;
    logic       adv;
    logic [7:0] cur_byte;

    assign full = (cnt_q == CW'(DEPTH));
    assign push = wr_en && !full && !rst;
    assign pop  = (state_q == IDLE) && (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= {wr_data, wr_len};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (push) begin
                wp_q <= wp_q + 1'b1;
            end
            if (pop) begin
                rp_q <= rp_q + 1'b1;
            end
            cnt_q <= cnt_d;
            if (wr_en && full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // MSB-first reads the byte indexed by the remaining count, so no shift.
    assign cur_byte = MSB_FIRST ? shreg_q[{rem_q, 3'b000} +: 8]
                                : shreg_q[7:0];

    // A byte is done once busy falls, or after a silent WAIT_HI timeout.
    assign adv = !tx_busy &&
                 ((state_q == WAIT_LO) ||
                  ((state_q == WAIT_HI) && (to_q == 3'd4)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            rem_q   <= '0;
            to_q    <= '0;
            sdata_q <= '0;
            start_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (adv) begin
                if (rem_q != 2'd0) begin
                    shreg_q <= MSB_FIRST ? shreg_q : (shreg_q >> 8);
                    rem_q   <= rem_q - 2'd1;
                    state_q <= SEND;
                end else begin
                    state_q <= IDLE;
                end
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (cnt_q != '0) begin
                            shreg_q <= mem_q[rp_q][33:2];
                            rem_q   <= mem_q[rp_q][1:0];
                            state_q <= SEND;
                        end
                    end
                    SEND: begin
                        if (!tx_busy) begin
                            sdata_q <= cur_byte;
                            start_q <= 1'b1;
                            to_q    <= '0;
                            state_q <= WAIT_HI;
                        end
                    end
                    WAIT_HI: begin
                        if (tx_busy) begin
                            state_q <= WAIT_LO;
                        end else begin
                            to_q <= to_q + 3'd1;
                        end
                    end
                    WAIT_LO: begin
                        state_q <= WAIT_LO;
                    end
                endcase
            end
        end
    end

    assign ovf      = ovf_q;
    assign sdata    = sdata_q;
    assign tx_start = start_q;
    assign idle     = (cnt_q == '0) && (state_q == IDLE);

endmodule

// File: tb/tb_uart_tx_seq.sv
// Bench for uart_tx_seq: an LSB-first and an MSB-first instance share stimulus
// and are checked each cycle against per-instance expected byte queues.
module tb_uart_tx_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic [1:0]  wr_len = '0;
    logic        tx_busy = 1'b0;

    logic        full, ovf, tx_start, idle;
    logic [7:0]  sdata;
    logic        full_m, ovf_m, tx_start_m, idle_m;
    logic [7:0]  sdata_m;

    always #5 clk = ~clk;

    uart_tx_seq #(.DEPTH_LOG2(2), .MSB_FIRST(1'b0)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .wr_len(wr_len), .full(full), .ovf(ovf), .tx_busy(tx_busy),
        .sdata(sdata), .tx_start(tx_start), .idle(idle)
    );

    uart_tx_seq #(.DEPTH_LOG2(2), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .wr_len(wr_len), .full(full_m), .ovf(ovf_m), .tx_busy(tx_busy),
        .sdata(sdata_m), .tx_start(tx_start_m), .idle(idle_m)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // 0: UART-like (10 busy cycles, one cycle after start), 1: high, 2: low
    int mode = 0;
    int busy_cnt = 0;
    bit start_seen = 0;

    always @(negedge clk) begin
        if (mode == 0) begin
            if (busy_cnt > 0) busy_cnt--;
            if (start_seen) busy_cnt = 10;
            start_seen = tx_start;
            tx_busy = (busy_cnt > 0);
        end else begin
            busy_cnt = 0;
            start_seen = 0;
            tx_busy = (mode == 1);
        end
    end

    bit          exp_acc = 0;
    int          cyc = 0;
    int          slog[$];
    logic [7:0]  q_l[$];
    logic [7:0]  q_m[$];
    logic [7:0]  last_l = '0;
    logic [7:0]  last_m = '0;
    logic [7:0]  e;
    bit          armed = 0;
    bit          s_rst, s_we, s_acc, s_busy;
    logic [31:0] s_d;
    logic [1:0]  s_l;

    always begin
        @(posedge clk);
        s_rst = rst; s_we = wr_en; s_acc = exp_acc;
        s_busy = tx_busy; s_d = wr_data; s_l = wr_len;
        cyc++;
        if (s_rst) begin
            armed = 1;
            q_l.delete();
            q_m.delete();
            last_l = '0;
            last_m = '0;
        end else if (s_we && s_acc) begin
            for (int i = 0; i <= int'(s_l); i++) begin
                q_l.push_back(s_d[8*i +: 8]);
                q_m.push_back(s_d[8*(int'(s_l)-i) +: 8]);
            end
        end
        #1;
        if (armed) begin
            if (tx_start) begin
                slog.push_back(cyc);
                chk("start_after_busy", {31'd0, s_busy}, 32'd0);
                chk("start_expected_l", {31'd0, q_l.size() > 0}, 32'd1);
                if (q_l.size() > 0) begin
                    e = q_l.pop_front();
                    chk("sdata_l", {24'd0, sdata}, {24'd0, e});
                    last_l = e;
                end
            end else begin
                chk("sdata_hold_l", {24'd0, sdata}, {24'd0, last_l});
            end
            if (tx_start_m) begin
                chk("start_expected_m", {31'd0, q_m.size() > 0}, 32'd1);
                if (q_m.size() > 0) begin
                    e = q_m.pop_front();
                    chk("sdata_m", {24'd0, sdata_m}, {24'd0, e});
                    last_m = e;
                end
            end else begin
                chk("sdata_hold_m", {24'd0, sdata_m}, {24'd0, last_m});
            end
        end
    end

    int pcyc = 0;

    task automatic push(input logic [31:0] d, input logic [1:0] l,
                        input bit acc);
        wr_data = d;
        wr_len = l;
        exp_acc = acc;
        wr_en = 1'b1;
        @(posedge clk);
        #1;
        pcyc = cyc;
        @(negedge clk);
        wr_en = 1'b0;
        exp_acc = 1'b0;
    endtask

    task automatic drain(input int budget);
        bit ok = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (idle && idle_m && q_l.size() == 0 && q_m.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk("drain", {31'd0, ok}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int base = 0;
    int p0 = 0;
    bit got2 = 0;
    logic [31:0] w3 [5] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    bit a3 [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_sdata", {24'd0, sdata}, 32'd0);
        chk("rst_start", {31'd0, tx_start}, 32'd0);
        chk("rst_idle", {31'd0, idle}, 32'd1);
        chk("rst_idle_m", {31'd0, idle_m}, 32'd1);

        // four-byte word with the UART-like busy model
        mode = 0;
        base = slog.size();
        push(32'h44332211, 2'd3, 1'b1);
        p0 = pcyc;
        drain(300);
        chk("t1_starts", slog.size() - base, 32'd4);
        chk("t1_latency", slog[base] - p0, 32'd2);
        chk("t1_gap", slog[base+1] - slog[base], 32'd13);
        chk("t1_last_l", {24'd0, sdata}, 32'h44);
        chk("t1_last_m", {24'd0, sdata_m}, 32'h11);

        // single byte
        base = slog.size();
        push(32'h000000A5, 2'd0, 1'b1);
        drain(100);
        chk("t2_starts", slog.size() - base, 32'd1);
        chk("t2_sdata_m", {24'd0, sdata_m}, 32'hA5);
        chk("t2_sdata_l", {24'd0, sdata}, 32'hA5);

        // overflow: word0 parks in SEND, then 5 pushes against 4 slots
        mode = 1;
        repeat (2) @(negedge clk);
        base = slog.size();
        push(32'h0000BEEF, 2'd1, 1'b1);
        repeat (3) @(negedge clk);
        chk("t3_full_pre", {31'd0, full}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            push(w3[i], 2'd0, a3[i]);
            if (i == 2) chk("t3_full_3", {31'd0, full}, 32'd0);
            if (i == 3) chk("t3_full_4", {31'd0, full}, 32'd1);
        end
        chk("t3_ovf", {31'd0, ovf}, 32'd1);
        chk("t3_ovf_m", {31'd0, ovf_m}, 32'd1);
        chk("t3_full_5", {31'd0, full}, 32'd1);
        chk("t3_no_start", slog.size() - base, 32'd0);
        mode = 0;
        drain(600);
        chk("t3_starts", slog.size() - base, 32'd6);
        chk("t3_ovf_sticky", {31'd0, ovf}, 32'd1);
        chk("t3_full_end", {31'd0, full}, 32'd0);
        chk("t3_last", {24'd0, sdata}, 32'h44);

        // push coinciding with the IDLE pop
        do_reset();
        chk("t4_ovf_clr", {31'd0, ovf}, 32'd0);
        base = slog.size();
        push(32'h77, 2'd0, 1'b1);
        push(32'h88, 2'd0, 1'b1);
        chk("t4_count", 32'(dut.cnt_q), 32'd1);
        drain(200);
        chk("t4_starts", slog.size() - base, 32'd2);
        chk("t4_last", {24'd0, sdata}, 32'h88);

        // reset during WAIT_LO of byte 2, with a push held during reset
        base = slog.size();
        push(32'hD4C3B2A1, 2'd3, 1'b1);
        push(32'h0000F1E2, 2'd1, 1'b1);
        push(32'h00000099, 2'd0, 1'b1);
        got2 = 0;
        for (int k = 0; k < 100; k++) begin
            if (slog.size() - base >= 2) begin
                got2 = 1;
                break;
            end
            @(negedge clk);
        end
        chk("t5_reach_b2", {31'd0, got2}, 32'd1);
        repeat (5) @(negedge clk);
        wr_data = 32'h12345678;
        wr_len = 2'd0;
        wr_en = 1'b1;
        do_reset();
        wr_en = 1'b0;
        chk("t5_idle", {31'd0, idle}, 32'd1);
        chk("t5_sdata", {24'd0, sdata}, 32'd0);
        chk("t5_sdata_m", {24'd0, sdata_m}, 32'd0);
        chk("t5_full", {31'd0, full}, 32'd0);
        repeat (60) @(negedge clk);
        chk("t5_starts", slog.size() - base, 32'd2);
        chk("t5_idle_end", {31'd0, idle}, 32'd1);

        // WAIT_HI timeout with tx_busy held low
        mode = 2;
        repeat (2) @(negedge clk);
        base = slog.size();
        push(32'h0000BBAA, 2'd1, 1'b1);
        p0 = pcyc;
        drain(100);
        chk("t6_starts", slog.size() - base, 32'd2);
        chk("t6_latency", slog[base] - p0, 32'd2);
        chk("t6_gap", slog[base+1] - slog[base], 32'd6);
        chk("t6_last_l", {24'd0, sdata}, 32'hBB);
        chk("t6_last_m", {24'd0, sdata_m}, 32'hAA);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
